// File: rtl/pwm_meter_pkg.sv
// Shared widths, state type and clamp helper for the PWM duty meter.
package pwm_meter_pkg;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DUTY_W = 10;
  localparam int unsigned NUM_W  = CNT_W + DUTY_W;
  localparam int unsigned QUOT_W = DUTY_W + 1;

  localparam logic [DUTY_W-1:0] DUTY_MAX      = 10'd1023;
  localparam logic [3:0]        DIV_LAST_ITER = 4'd10;

  typedef enum logic [0:0] {
    StIdle,
    StMeasure
  } meter_state_e;

  // Quotient 1024 only arises for high == period; saturate it to full scale.
  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [QUOT_W-1:0] q);
    return q[QUOT_W-1] ? DUTY_MAX : q[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/duty_divider.sv
// Restoring divider: one load cycle, then 11 compare/subtract iterations.
module duty_divider
  import pwm_meter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NUM_W-1:0]  numerator,
  input  logic [CNT_W-1:0]  divisor,
  output logic              busy,
  output logic [QUOT_W-1:0] quotient,
  output logic              done
);

  logic              run_q;
  logic              hold_q;
  logic [3:0]        iter_q;
  logic [NUM_W-1:0]  rem_q;
  logic [NUM_W-1:0]  dsh_q;
  logic [QUOT_W-2:0] quot_q;
  logic              fits;

  // Quotient is only meaningful while done is high (final iteration cycle).
  always_comb begin
    fits     = (rem_q >= dsh_q);
    quotient = {quot_q, fits};
    done     = run_q && (iter_q == DIV_LAST_ITER);
    busy     = run_q | hold_q;
  end

  // The result-delivery cycle still reads as busy, so a window ending there is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q  <= 1'b0;
      hold_q <= 1'b0;
      iter_q <= '0;
      rem_q  <= '0;
      dsh_q  <= '0;
      quot_q <= '0;
    end else begin
      hold_q <= done;
      if (run_q) begin
        if (fits) begin
          rem_q <= rem_q - dsh_q;
        end
        dsh_q  <= dsh_q >> 1;
        quot_q <= quotient[QUOT_W-2:0];
        iter_q <= iter_q + 4'd1;
        if (done) begin
          run_q <= 1'b0;
        end
      end else if (start && !hold_q) begin
        run_q  <= 1'b1;
        iter_q <= '0;
        rem_q  <= numerator;
        dsh_q  <= {divisor, {DUTY_W{1'b0}}};
        quot_q <= '0;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures PWM duty as high*1024/period per rising-edge window, with stuck detection.
module pwm_duty_meter
  import pwm_meter_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 16'd40000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic              stuck,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] TimeoutLast = TIMEOUT_CYCLES - 1'b1;

  logic              sync1_q, sync2_q, prev_q;
  logic              rise;
  meter_state_e      state_q, state_d;
  logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              valid_q, valid_d;
  logic              stuck_q, stuck_d;
  logic              overrun_q, overrun_d;
  logic              div_start, div_busy, div_done;
  logic [NUM_W-1:0]  div_num;
  logic [QUOT_W-1:0] div_quot;

  assign rise    = sync2_q & ~prev_q;
  assign div_num = {high_cnt_q, {DUTY_W{1'b0}}};

  duty_divider u_divider (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .numerator (div_num),
    .divisor   (period_cnt_q),
    .busy      (div_busy),
    .quotient  (div_quot),
    .done      (div_done)
  );

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    duty_d       = duty_q;
    valid_d      = 1'b0;
    stuck_d      = stuck_q;
    overrun_d    = overrun_q;
    div_start    = 1'b0;

    if (period_cnt_q != TIMEOUT_CYCLES) begin
      period_cnt_d = period_cnt_q + 1'b1;
    end
    if (state_q == StMeasure && sync2_q) begin
      high_cnt_d = high_cnt_q + 1'b1;
    end

    if (div_done) begin
      duty_d  = clamp_duty(div_quot);
      valid_d = 1'b1;
    end

    // Rise cycle is cycle 1 of the next window; a rise beats a coincident timeout.
    if (rise) begin
      period_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
      high_cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
      stuck_d      = 1'b0;
      state_d      = StMeasure;
      if (state_q == StMeasure) begin
        if (div_busy) begin
          overrun_d = 1'b1;
        end else begin
          div_start = 1'b1;
        end
      end
    end else if (period_cnt_q == TimeoutLast) begin
      stuck_d = 1'b1;
      duty_d  = sync2_q ? DUTY_MAX : '0;
      valid_d = 1'b1;
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      state_q      <= StIdle;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      duty_q       <= '0;
      valid_q      <= 1'b0;
      stuck_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= pwm_in;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      duty_q       <= duty_d;
      valid_q      <= valid_d;
      stuck_q      <= stuck_d;
      overrun_q    <= overrun_d;
    end
  end

  assign duty       = duty_q;
  assign duty_valid = valid_q;
  assign stuck      = stuck_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Randomized and directed bench for pwm_duty_meter against a window-level reference model.
module tb_pwm_duty_meter;
  import pwm_meter_pkg::*;

  localparam int Timeout   = 5000;
  localparam int HistDepth = 32768;

  logic              clk, reset, pwm_in;
  logic [DUTY_W-1:0] duty;
  logic              duty_valid, stuck, overrun;

  logic              u_reset, u_start;
  logic [NUM_W-1:0]  u_num;
  logic [CNT_W-1:0]  u_div;
  logic              u_busy, u_done;
  logic [QUOT_W-1:0] u_quot;

  pwm_duty_meter #(
    .TIMEOUT_CYCLES (16'(Timeout))
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .duty       (duty),
    .duty_valid (duty_valid),
    .stuck      (stuck),
    .overrun    (overrun)
  );

  duty_divider u_div_unit (
    .clk       (clk),
    .reset     (u_reset),
    .start     (u_start),
    .numerator (u_num),
    .divisor   (u_div),
    .busy      (u_busy),
    .quotient  (u_quot),
    .done      (u_done)
  );

  always #5 clk = ~clk;

  int n_vec, n_err, cyc, n_pulse;
  bit wave_hist [HistDepth];

  // Reference model state: windows between synchronized rises.
  bit meas, exp_val, exp_stk, exp_ovr;
  int ref_c, last_ho, exp_duty;
  int due_q[$];
  int val_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, want);
    end
  endtask

  // Synchronized input as seen by the meter: the driven wave two cycles late.
  function automatic bit sv(input int k);
    if (k < 2 || k - 2 >= HistDepth) return 1'b0;
    return wave_hist[k-2];
  endfunction

  task automatic model_reset();
    cyc = 0; meas = 0; ref_c = 0; last_ho = -100;
    exp_val = 0; exp_stk = 0; exp_ovr = 0; exp_duty = 0;
    due_q.delete(); val_q.delete();
  endtask

  task automatic step(input bit w);
    bit rise, nv;
    int p, h, q;
    check_val("duty_valid", duty_valid, exp_val);
    check_val("duty", duty, exp_duty);
    check_val("stuck", stuck, exp_stk);
    check_val("overrun", overrun, exp_ovr);
    if (duty_valid === 1'b1) n_pulse++;
    pwm_in = w;
    if (cyc < HistDepth) wave_hist[cyc] = w;
    rise = sv(cyc) && !sv(cyc - 1);
    nv = 0;
    if (rise) begin
      if (meas) begin
        if (cyc - last_ho <= 12) begin
          exp_ovr = 1;
        end else begin
          p = cyc - ref_c;
          h = 0;
          for (int k = ref_c; k < cyc; k++) h += int'(sv(k));
          q = (h * 1024) / p;
          if (q > 1023) q = 1023;
          due_q.push_back(cyc + 12);
          val_q.push_back(q);
          last_ho = cyc;
        end
      end
      meas = 1; ref_c = cyc; exp_stk = 0;
    end else if (cyc - ref_c == Timeout - 1) begin
      exp_stk = 1; exp_duty = sv(cyc) ? 1023 : 0; nv = 1; meas = 0;
      if (due_q.size() > 0 && due_q[0] == cyc + 1) begin
        void'(due_q.pop_front()); void'(val_q.pop_front());
      end
    end
    if (due_q.size() > 0 && due_q[0] == cyc + 1) begin
      exp_duty = val_q[0]; nv = 1;
      void'(due_q.pop_front()); void'(val_q.pop_front());
    end
    exp_val = nv;
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_wave(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) step((i % p) < h);
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1; pwm_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      check_val("rst_duty", duty, 0);
      check_val("rst_valid", duty_valid, 0);
      check_val("rst_stuck", stuck, 0);
      check_val("rst_overrun", overrun, 0);
      @(negedge clk);
    end
    reset = 1'b0;
    model_reset();
    n_pulse = 0;
  endtask

  task automatic div_case(input int hi, input int den);
    int want;
    bit seen;
    want = (hi * 1024) / den;
    u_num = {16'(hi), 10'b0};
    u_div = 16'(den);
    u_start = 1'b1;
    @(negedge clk);
    u_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (u_done === 1'b1) begin
        seen = 1;
        check_val("div_quotient", u_quot, want);
      end else begin
        @(negedge clk);
      end
    end
    check_val("div_done_seen", seen, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int den, p, h;
    clk = 0; reset = 1; u_reset = 1; pwm_in = 0; u_start = 0; u_num = '0; u_div = '0;
    n_vec = 0; n_err = 0; cyc = 0; n_pulse = 0;
    repeat (2) @(negedge clk);
    u_reset = 0;
    div_case(4000, 4000);
    div_case(2929, 4001);
    div_case(2000, 4000);
    div_case(1, 65535);
    for (int i = 0; i < 4; i++) begin
      den = int'($urandom_range(1, 65535));
      div_case(int'($urandom_range(0, den)), den);
    end

    // 25 kHz generator, duty 750
    apply_reset(3);
    run_wave(4001, 2929, 12203);
    check_val("duty_25k", duty, 749);
    check_val("pulses_25k", n_pulse, 3);
    check_val("stuck_25k", stuck, 0);
    check_val("overrun_25k", overrun, 0);

    // Held low, then 2000/4000 square wave
    apply_reset(3);
    for (int i = 0; i < 5100; i++) step(1'b0);
    check_val("stuck_low", stuck, 1);
    check_val("duty_low", duty, 0);
    check_val("pulses_low", n_pulse, 1);
    run_wave(4000, 2000, 12100);
    check_val("stuck_cleared", stuck, 0);
    check_val("duty_square", duty, 512);

    // One rise, then held high
    apply_reset(3);
    for (int i = 0; i < 5200; i++) step(1'b1);
    check_val("duty_high", duty, 1023);
    check_val("stuck_high", stuck, 1);

    // Fast wave forces overrun; it stays sticky through slower input
    apply_reset(3);
    run_wave(8, 4, 200);
    check_val("overrun_fast", overrun, 1);
    run_wave(50, 20, 400);
    check_val("overrun_sticky", overrun, 1);

    // Random segments, some shorter than the divider latency
    apply_reset(3);
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 3) == 0) p = int'($urandom_range(4, 16));
      else p = int'($urandom_range(13, 200));
      h = int'($urandom_range(1, p - 1));
      run_wave(p, h, p * int'($urandom_range(1, 3)));
    end

    // Reset 5 clk after a rise in MEASURE aborts the divide
    apply_reset(3);
    run_wave(100, 50, 107);
    apply_reset(2);
    check_val("abort_no_pulse", n_pulse, 0);
    run_wave(100, 50, 300);
    check_val("pulses_after_abort", n_pulse, 2);
    check_val("duty_after_abort", duty, 512);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
